// File: rtl/i2c_pkg.sv
// Shared definitions for the configuration register bank arbiter.
package i2c_pkg;

    localparam int unsigned NUM_REGS_DEF = 9;
    localparam int unsigned REG_AW       = 5;

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1,
        StCommit
    } arb_state_t;

    // Requester index: 0 = I2C slave, 1 = IO block.
    typedef logic req_idx_t;

endpackage

// File: rtl/burst_counter.sv
// Per-burst beat counter: saturating 4-bit count with a reached-limit flag.
module burst_counter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_reached
);

    logic [3:0] r_count;
    logic [3:0] w_count_inc;

    always_comb begin
        w_count_inc = (r_count == 4'hF) ? r_count : r_count + 4'd1;
        // Flag is combinational so the limiting beat itself ends the burst.
        o_reached   = i_inc && (w_count_inc >= 4'(MAX_BURST));
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= 4'd0;
        end else if (i_clear) begin
            r_count <= 4'd0;
        end else if (i_inc) begin
            r_count <= w_count_inc;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-requester arbiter for the shared register bank: one owner per burst,
// writes staged privately and committed to the packed bank in a single cycle.
module reg_bank_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
    parameter int unsigned MAX_BURST = 8,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic [1:0]              i_req,
    input  logic [1:0]              i_last,
    input  logic [1:0]              i_we,
    input  logic [2*REG_AW-1:0]     i_addr,
    input  logic [15:0]             i_wdata,
    output logic [1:0]              o_gnt,
    output logic [7:0]              o_rdata,
    output logic                    o_rvalid,
    output logic [1:0]              o_err,
    output logic                    o_busy,
    output logic [8*NUM_REGS-1:0]   o_regs_packed
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    arb_state_t r_state;
    arb_state_t w_state_next;
    req_idx_t   r_owner;
    req_idx_t   r_ptr;
    req_idx_t   w_owner;
    req_idx_t   w_winner;

    logic [7:0] r_stage [NUM_REGS];
    logic [7:0] r_bank  [NUM_REGS];

    logic              w_owned;
    logic              w_req_o;
    logic              w_last_o;
    logic              w_we_o;
    logic              w_beat;
    logic              w_in_range;
    logic              w_reached;
    logic              w_grant;
    logic [REG_AW-1:0] w_addr_o;
    logic [7:0]        w_wdata_o;
    logic [IDX_W-1:0]  w_idx;

    logic [7:0] r_rdata;
    logic       r_rvalid;
    logic [1:0] r_err;

    // Only the owner's lanes are looked at; the other requester is muted.
    always_comb begin
        w_owned    = (r_state == StOwn0) || (r_state == StOwn1);
        w_owner    = (r_state == StOwn1);
        w_req_o    = i_req[w_owner];
        w_last_o   = i_last[w_owner];
        w_we_o     = i_we[w_owner];
        w_addr_o   = w_owner ? i_addr[2*REG_AW-1:REG_AW] : i_addr[REG_AW-1:0];
        w_wdata_o  = w_owner ? i_wdata[15:8] : i_wdata[7:0];
        w_beat     = w_owned && w_req_o;
        w_in_range = 32'(w_addr_o) < NUM_REGS;
        w_idx      = w_addr_o[IDX_W-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_winner     = r_ptr;
        unique case (r_state)
            StIdle: begin
                if (|i_req) begin
                    w_grant      = 1'b1;
                    w_winner     = (i_req == 2'b11) ? r_ptr : i_req[1];
                    w_state_next = w_winner ? StOwn1 : StOwn0;
                end
            end
            StOwn0, StOwn1: begin
                if (!w_req_o || (w_beat && (w_last_o || w_reached))) begin
                    w_state_next = StCommit;
                end
            end
            StCommit: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    burst_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_counter (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_grant),
        .i_inc     (w_beat),
        .o_reached (w_reached)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= StIdle;
            r_owner  <= 1'b0;
            r_ptr    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= 8'h00;
            r_err    <= 2'b00;
        end else begin
            r_state  <= w_state_next;
            if (w_grant) begin
                r_owner <= w_winner;
            end
            if (r_state == StCommit) begin
                r_ptr <= ~r_owner;
            end
            r_rvalid <= w_beat && !w_we_o;
            r_rdata  <= (w_beat && !w_we_o && w_in_range) ? r_stage[w_idx] : 8'h00;
            r_err    <= (w_beat && !w_in_range) ? (w_owner ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                r_stage[k] <= RESET_VAL;
                r_bank[k]  <= RESET_VAL;
            end
        end else begin
            if (w_grant) begin
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    r_stage[k] <= r_bank[k];
                end
            end else if (w_beat && w_we_o && w_in_range) begin
                r_stage[w_idx] <= w_wdata_o;
            end
            if (r_state == StCommit) begin
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    r_bank[k] <= r_stage[k];
                end
            end
        end
    end

    always_comb begin
        o_gnt = 2'b00;
        if (r_state == StOwn0) begin
            o_gnt = 2'b01;
        end else if (r_state == StOwn1) begin
            o_gnt = 2'b10;
        end
        o_busy   = (r_state != StIdle);
        o_rdata  = r_rdata;
        o_rvalid = r_rvalid;
        o_err    = r_err;
        o_regs_packed = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            o_regs_packed[8*k +: 8] = r_bank[k];
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_reg_bank_arbiter;

    localparam int NREG = 9;
    localparam int MAXB = 8;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  last;
    logic [1:0]  we;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [7:0]  rdata;
    logic        rvalid;
    logic [1:0]  err;
    logic        busy;
    logic [71:0] regs;

    int total;
    int bad;

    reg_bank_arbiter #(
        .NUM_REGS  (NREG),
        .MAX_BURST (MAXB),
        .RESET_VAL (8'h00)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_req         (req),
        .i_last        (last),
        .i_we          (we),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .o_gnt         (gnt),
        .o_rdata       (rdata),
        .o_rvalid      (rvalid),
        .o_err         (err),
        .o_busy        (busy),
        .o_regs_packed (regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (burst/transaction view) ----------------
    int          m_phase;   // 0 idle, 1 owning, 2 committing
    int          m_own;
    int          m_ptr;
    int          m_beats;
    byte unsigned m_bank  [NREG];
    byte unsigned m_stage [NREG];
    logic        m_rvalid;
    logic [7:0]  m_rdata;
    logic [1:0]  m_err;

    function automatic void model_reset();
        m_phase = 0; m_own = 0; m_ptr = 0; m_beats = 0;
        m_rvalid = 1'b0; m_rdata = 8'h00; m_err = 2'b00;
        for (int k = 0; k < NREG; k++) begin
            m_bank[k] = 8'h00;
            m_stage[k] = 8'h00;
        end
    endfunction

    function automatic void model_step();
        int a;
        byte unsigned d;
        m_rvalid = 1'b0; m_rdata = 8'h00; m_err = 2'b00;
        if (m_phase == 0) begin
            if (req != 2'b00) begin
                m_own   = (req == 2'b11) ? m_ptr : (req[1] ? 1 : 0);
                m_phase = 1;
                m_beats = 0;
                m_stage = m_bank;
            end
        end else if (m_phase == 1) begin
            if (!req[m_own]) begin
                m_phase = 2;
            end else begin
                a = (m_own == 1) ? int'(addr[9:5]) : int'(addr[4:0]);
                d = (m_own == 1) ? wdata[15:8] : wdata[7:0];
                m_beats++;
                if (a >= NREG) m_err = (m_own == 1) ? 2'b10 : 2'b01;
                else if (we[m_own]) m_stage[a] = d;
                if (!we[m_own]) begin
                    m_rvalid = 1'b1;
                    m_rdata  = (a < NREG) ? m_stage[a] : 8'h00;
                end
                if (last[m_own] || m_beats >= MAXB) m_phase = 2;
            end
        end else begin
            m_bank  = m_stage;
            m_ptr   = 1 - m_own;
            m_phase = 0;
        end
    endfunction

    function automatic logic [71:0] model_regs();
        logic [71:0] v;
        for (int k = 0; k < NREG; k++) v[8*k +: 8] = m_bank[k];
        return v;
    endfunction

    function automatic logic [1:0] model_gnt();
        if (m_phase != 1) return 2'b00;
        return (m_own == 1) ? 2'b10 : 2'b01;
    endfunction

    // ---------------- helpers ----------------
    function automatic void chk(string nm, logic [71:0] got, logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        req = r; last = l; we = w; addr = {a1, a0}; wdata = {d1, d0};
    endtask

    // Model advances with the inputs the DUT samples at this edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        model_reset();
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0] req;
        logic [1:0] last;
        logic [1:0] we;
        logic [4:0] a0;
        logic [4:0] a1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] gnt;
        logic       busy;
        logic       rvalid;
        logic [7:0] rdata;
        logic [1:0] err;
        int         idx;
        logic [7:0] val;
    } vec_t;

    vec_t tbl [13];

    logic [1:0]  alt_gnt [7];
    logic [71:0] exp_regs;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);

        // req  last   we     a0 a1 d0     d1      gnt   busy rv    rdata  err  idx val
        tbl[0]  = '{2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b01, 1'b1, 1'b0, 8'h00, 2'b00, 2, 8'h00};
        tbl[1]  = '{2'b01, 2'b00, 2'b01, 5'd2, 5'd0, 8'hA5, 8'h00, 2'b01, 1'b1, 1'b0, 8'h00, 2'b00, 2, 8'h00};
        tbl[2]  = '{2'b01, 2'b01, 2'b01, 5'd3, 5'd0, 8'h3C, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 3, 8'h00};
        tbl[3]  = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 2, 8'hA5};
        tbl[4]  = '{2'b10, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b10, 1'b1, 1'b0, 8'h00, 2'b00, 3, 8'h3C};
        tbl[5]  = '{2'b10, 2'b00, 2'b10, 5'd0, 5'd0, 8'h00, 8'h77, 2'b10, 1'b1, 1'b0, 8'h00, 2'b00, 0, 8'h00};
        tbl[6]  = '{2'b10, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b10, 1'b1, 1'b1, 8'h77, 2'b00, 0, 8'h00};
        tbl[7]  = '{2'b10, 2'b10, 2'b00, 5'd0, 5'd2, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 8'hA5, 2'b00, 0, 8'h00};
        tbl[8]  = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 0, 8'h77};
        tbl[9]  = '{2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b01, 1'b1, 1'b0, 8'h00, 2'b00, 8, 8'h00};
        tbl[10] = '{2'b01, 2'b00, 2'b01, 5'd9, 5'd0, 8'hEE, 8'h00, 2'b01, 1'b1, 1'b0, 8'h00, 2'b01, 8, 8'h00};
        tbl[11] = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 8, 8'h00};
        tbl[12] = '{2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8, 8'h00};

        alt_gnt[0] = 2'b01; alt_gnt[1] = 2'b00; alt_gnt[2] = 2'b00; alt_gnt[3] = 2'b10;
        alt_gnt[4] = 2'b00; alt_gnt[5] = 2'b00; alt_gnt[6] = 2'b01;

        do_reset();
        chk("reset_gnt", 72'(gnt), 72'(2'b00));
        chk("reset_busy", 72'(busy), 72'(1'b0));
        chk("reset_regs", regs, 72'h0);

        // Single-owner write/commit, read-your-writes, error and abandon.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].req, tbl[i].last, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            tick();
            chk($sformatf("tbl%0d_gnt", i), 72'(gnt), 72'(tbl[i].gnt));
            chk($sformatf("tbl%0d_busy", i), 72'(busy), 72'(tbl[i].busy));
            chk($sformatf("tbl%0d_rvalid", i), 72'(rvalid), 72'(tbl[i].rvalid));
            if (tbl[i].rvalid) chk($sformatf("tbl%0d_rdata", i), 72'(rdata), 72'(tbl[i].rdata));
            chk($sformatf("tbl%0d_err", i), 72'(err), 72'(tbl[i].err));
            chk($sformatf("tbl%0d_reg", i), 72'(regs[8*tbl[i].idx +: 8]), 72'(tbl[i].val));
        end
        chk("tbl_final_bank", regs, 72'h00000000003CA50077);

        // Reset in the middle of an IO-block burst with two staged writes.
        drive(2'b10, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        tick();
        drive(2'b10, 2'b00, 2'b10, 5'd0, 5'd0, 8'h00, 8'hAA);
        tick();
        drive(2'b10, 2'b00, 2'b10, 5'd0, 5'd1, 8'h00, 8'hBB);
        tick();
        chk("midrst_owned", 72'(gnt), 72'(2'b10));
        rst_n = 1'b0;
        #2;
        chk("midrst_gnt", 72'(gnt), 72'(2'b00));
        chk("midrst_busy", 72'(busy), 72'(1'b0));
        chk("midrst_regs", regs, 72'h0);
        model_reset();

        // Both requesting out of reset: 0 first, then strict alternation.
        drive(2'b11, 2'b11, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("alt%0d_gnt", i), 72'(gnt), 72'(alt_gnt[i]));
        end

        // Forced handoff: requester 0 streams 10 writes, requester 1 waits.
        do_reset();
        drive(2'b11, 2'b10, 2'b01, 5'd0, 5'd0, 8'h00, 8'h00);
        tick();
        chk("force_grant0", 72'(gnt), 72'(2'b01));
        exp_regs = '0;
        for (int k = 0; k < 8; k++) exp_regs[8*k +: 8] = 8'(8'h11 + k);
        for (int c = 1; c <= 10; c++) begin
            drive(2'b11, 2'b10, 2'b01, 5'((c - 1) % 9), 5'd0, 8'(8'h10 + c), 8'h00);
            tick();
            if (c == 7) chk("force_still_owned", 72'(gnt), 72'(2'b01));
            if (c == 8) chk("force_commit_gnt", 72'(gnt), 72'(2'b00));
            if (c == 9) chk("force_commit_regs", regs, exp_regs);
            if (c == 10) chk("force_handoff_gnt", 72'(gnt), 72'(2'b10));
        end
        drive(2'b10, 2'b10, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        tick();
        chk("force_own1_done", 72'(gnt), 72'(2'b00));
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        tick();
        chk("force_late_beats_dropped", regs, exp_regs);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            req[0] = req[0] ^ ($urandom_range(0, 5) == 0);
            req[1] = req[1] ^ ($urandom_range(0, 5) == 0);
            last   = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            we     = 2'($urandom_range(0, 3));
            addr   = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
            wdata  = 16'($urandom);
            tick();
            chk("rnd_gnt", 72'(gnt), 72'(model_gnt()));
            chk("rnd_busy", 72'(busy), 72'(m_phase != 0));
            chk("rnd_rvalid", 72'(rvalid), 72'(m_rvalid));
            if (m_rvalid) chk("rnd_rdata", 72'(rdata), 72'(m_rdata));
            chk("rnd_err", 72'(err), 72'(m_err));
            chk("rnd_regs", regs, model_regs());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
